lcd_display_model: RTL and testbench

Synthesizable HD44780-compatible responder for the 16x2 character LCD write interface: it accepts the same LCD_DATA/LCD_RS/LCD_RW/LCD_EN signals our LCD controller drives and decodes them the way the display does. It maintains the 32-character screen image, a busy window and protocol-violation flags. It sits on-chip in loopback with the LCD controller, for self-test and for mirroring the screen to other outputs such as debug readout and a future VGA text overlay.

---
 rtl/lcd_display_model.sv | 160 ++++++++++++++++
 tb/tb_lcd_display_model.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_model.sv
// HD44780-style write-side responder for a 16x2 LCD.
// Decodes controller writes into a screen image plus busy/error status.
module lcd_display_model #(
  parameter int EN_MIN_HIGH  = 8,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iLCD_DATA,
  input  logic       iLCD_RS,
  input  logic       iLCD_RW,
  input  logic       iLCD_EN,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_CHAR,
  output logic       oBUSY,
  output logic [6:0] oAC,
  output logic       oDISP_ON,
  output logic       oFUNC_OK,
  output logic       oCMD_STB,
  output logic       oDATA_STB,
  output logic       oERR_TIMING,
  output logic       oERR_BUSY
);

  localparam int BMAX = (CLEAR_CYCLES > BUSY_CYCLES) ?
                        CLEAR_CYCLES : BUSY_CYCLES;
  localparam int BW = $clog2(BMAX + 1);
  localparam int HW = $clog2(EN_MIN_HIGH + 2);
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [HW-1:0] HMIN = HW'(EN_MIN_HIGH);
  localparam logic [BW-1:0] BNRM = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] BCLR = BW'(CLEAR_CYCLES);

  logic          enQ;
  logic [HW-1:0] hiCnt;
  logic [7:0]    capData;
  logic          capRs;
  logic          capRw;
  logic [BW-1:0] busyCnt;
  logic          incMode;
  logic          clearing;
  logic [4:0]    clrIdx;
  logic [7:0]    scrBuf [32];

  logic       fallEdge;
  logic       tooShort;
  logic       wrOk;
  logic [4:0] wrIdx;

  assign fallEdge = enQ & ~iLCD_EN;
  assign tooShort = hiCnt < HMIN;
  assign oBUSY    = (busyCnt != '0);
  assign wrOk     = (oAC[6:4] == 3'b000) | (oAC[6:4] == 3'b100);
  assign wrIdx    = {oAC[6], oAC[3:0]};

  // Next address counter value, with the two-line DDRAM wrap rules.
  function automatic logic [6:0] acStep(input logic [6:0] a,
                                        input logic       up);
    logic [6:0] n;
    if (up) begin
      if (a >= 7'h67)                   n = 7'h00;
      else if (a >= 7'h27 && a <= 7'h3F) n = 7'h40;
      else                              n = a + 7'd1;
    end else begin
      if (a == 7'h00)      n = 7'h67;
      else if (a == 7'h40) n = 7'h27;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

  // Track EN, latch the bus while EN is high and time the high phase.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      enQ     <= 1'b0;
      hiCnt   <= '0;
      capData <= 8'h00;
      capRs   <= 1'b0;
      capRw   <= 1'b0;
    end else begin
      enQ <= iLCD_EN;
      if (iLCD_EN) begin
        capData <= iLCD_DATA;
        capRs   <= iLCD_RS;
        capRw   <= iLCD_RW;
        if (!enQ)              hiCnt <= HW'(1);
        else if (hiCnt != HMAX) hiCnt <= hiCnt + HW'(1);
      end
    end
  end

  // Execute transactions on EN fall; run busy window and clear fill.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) scrBuf[i] <= 8'h20;
      oRD_CHAR    <= 8'h00;
      oAC         <= 7'h00;
      incMode     <= 1'b1;
      oDISP_ON    <= 1'b0;
      oFUNC_OK    <= 1'b0;
      oCMD_STB    <= 1'b0;
      oDATA_STB   <= 1'b0;
      oERR_TIMING <= 1'b0;
      oERR_BUSY   <= 1'b0;
      busyCnt     <= '0;
      clearing    <= 1'b0;
      clrIdx      <= 5'd0;
    end else begin
      oRD_CHAR  <= scrBuf[iRD_ADDR];
      oCMD_STB  <= 1'b0;
      oDATA_STB <= 1'b0;
      if (oBUSY) busyCnt <= busyCnt - BW'(1);
      if (clearing) begin
        scrBuf[clrIdx] <= 8'h20;
        clrIdx <= clrIdx + 5'd1;
        if (clrIdx == 5'd31) clearing <= 1'b0;
      end
      if (fallEdge) begin
        if (tooShort) begin
          oERR_TIMING <= 1'b1;
        end else if (capRw) begin
          oERR_TIMING <= oERR_TIMING;
        end else if (oBUSY) begin
          oERR_BUSY <= 1'b1;
        end else if (capRs) begin
          if (wrOk) scrBuf[wrIdx] <= capData;
          oAC       <= acStep(oAC, incMode);
          oDATA_STB <= 1'b1;
          busyCnt   <= BNRM;
        end else if (capData != 8'h00) begin
          oCMD_STB <= 1'b1;
          busyCnt  <= BNRM;
          priority case (1'b1)
            capData[7]: oAC <= capData[6:0];
            capData[6]: oCMD_STB <= 1'b1;
            capData[5]: oFUNC_OK <= capData[4] & capData[3];
            capData[4]: begin
              if (!capData[3]) oAC <= acStep(oAC, capData[2]);
            end
            capData[3]: oDISP_ON <= capData[2];
            capData[2]: incMode <= capData[1];
            capData[1]: begin
              oAC     <= 7'h00;
              busyCnt <= BCLR;
            end
            default: begin
              oAC      <= 7'h00;
              incMode  <= 1'b1;
              busyCnt  <= BCLR;
              clearing <= 1'b1;
              clrIdx   <= 5'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_display_model.sv
// Self-checking bench for lcd_display_model.
// Vector table, directed corner cases and random traffic vs a model.
module tb_lcd_display_model;

  localparam int EMIN = 8;
  localparam int BUSY = 50;
  localparam int CLR  = 80;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic [7:0] iLCD_DATA = 8'h00;
  logic       iLCD_RS = 1'b0;
  logic       iLCD_RW = 1'b0;
  logic       iLCD_EN = 1'b0;
  logic [4:0] iRD_ADDR = 5'd0;
  logic [7:0] oRD_CHAR;
  logic       oBUSY;
  logic [6:0] oAC;
  logic       oDISP_ON;
  logic       oFUNC_OK;
  logic       oCMD_STB;
  logic       oDATA_STB;
  logic       oERR_TIMING;
  logic       oERR_BUSY;

  lcd_display_model #(
    .EN_MIN_HIGH(EMIN),
    .BUSY_CYCLES(BUSY),
    .CLEAR_CYCLES(CLR)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iLCD_DATA(iLCD_DATA), .iLCD_RS(iLCD_RS),
    .iLCD_RW(iLCD_RW), .iLCD_EN(iLCD_EN),
    .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
    .oBUSY(oBUSY), .oAC(oAC),
    .oDISP_ON(oDISP_ON), .oFUNC_OK(oFUNC_OK),
    .oCMD_STB(oCMD_STB), .oDATA_STB(oDATA_STB),
    .oERR_TIMING(oERR_TIMING), .oERR_BUSY(oERR_BUSY)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nErr = 0;
  int cyc = 0;
  int busyEnd = -1000;

  // reference model state
  int         mAc;
  bit         mInc, mDisp, mFunc, mErrT, mErrB;
  logic [7:0] mBuf [32];

  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic [6:0] ac;
    logic       cs;
    logic       ds;
    logic       fok;
    logic       don;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    cyc++;
    #1;
  endtask

  task automatic modelReset();
    mAc = 0; mInc = 1; mDisp = 0; mFunc = 0;
    mErrT = 0; mErrB = 0;
    busyEnd = -1000;
    for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
  endtask

  function automatic int nextAc(input int a, input bit up);
    if (up) begin
      if (a >= 'h67) return 0;
      if (a >= 'h27 && a < 'h40) return 'h40;
      return a + 1;
    end
    if (a == 0) return 'h67;
    if (a == 'h40) return 'h27;
    return a - 1;
  endfunction

  function automatic int scrIndex(input int a);
    if (a < 16) return a;
    if (a >= 'h40 && a < 'h50) return 16 + a - 'h40;
    return -1;
  endfunction

  // effect of one EN falling edge seen at cycle cyc
  task automatic modelTxn(input logic [7:0] d, input logic rs,
                          input logic rw, input int hi,
                          output bit cs, output bit ds);
    int idx;
    cs = 0; ds = 0;
    if (hi < EMIN) mErrT = 1;
    else if (rw) begin
      cs = 0;
    end else if (cyc <= busyEnd) mErrB = 1;
    else if (rs) begin
      idx = scrIndex(mAc);
      if (idx >= 0) mBuf[idx] = d;
      mAc = nextAc(mAc, mInc);
      ds = 1;
      busyEnd = cyc + BUSY;
    end else if (d != 0) begin
      cs = 1;
      busyEnd = cyc + BUSY;
      if (d >= 128) mAc = d - 128;
      else if (d >= 64) cs = 1;
      else if (d >= 32) mFunc = d[4] & d[3];
      else if (d >= 16) begin
        if (!d[3]) mAc = nextAc(mAc, d[2]);
      end else if (d >= 8) mDisp = d[2];
      else if (d >= 4) mInc = d[1];
      else if (d >= 2) begin
        mAc = 0;
        busyEnd = cyc + CLR;
      end else begin
        mAc = 0; mInc = 1;
        for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
        busyEnd = cyc + CLR;
      end
    end
  endtask

  task automatic pulse(input logic [7:0] d, input logic rs,
                       input logic rw, input int hi);
    bit ecs, eds;
    iLCD_DATA = d; iLCD_RS = rs; iLCD_RW = rw; iLCD_EN = 1'b1;
    repeat (hi) tick();
    iLCD_EN = 1'b0;
    iLCD_DATA = 8'($urandom);
    iLCD_RS = 1'($urandom);
    iLCD_RW = 1'($urandom);
    tick();
    modelTxn(d, rs, rw, hi, ecs, eds);
    chk("cmdStb", oCMD_STB, ecs);
    chk("dataStb", oDATA_STB, eds);
    chk("ac", oAC, mAc);
    chk("dispOn", oDISP_ON, mDisp);
    chk("funcOk", oFUNC_OK, mFunc);
    chk("errTiming", oERR_TIMING, mErrT);
    chk("errBusy", oERR_BUSY, mErrB);
    chk("busy", oBUSY, cyc < busyEnd);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (oBUSY !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      nChecks++;
      nErr++;
      $display("FAIL idleTimeout busy still %b", oBUSY);
    end
  endtask

  task automatic checkBuf();
    for (int i = 0; i < 32; i++) begin
      iRD_ADDR = 5'(i);
      tick();
      chk($sformatf("buf%0d", i), oRD_CHAR, mBuf[i]);
    end
  endtask

  task automatic chkResetOuts();
    chk("rstAc", oAC, 0);
    chk("rstBusy", oBUSY, 0);
    chk("rstRd", oRD_CHAR, 0);
    chk("rstDisp", oDISP_ON, 0);
    chk("rstFunc", oFUNC_OK, 0);
    chk("rstCmdStb", oCMD_STB, 0);
    chk("rstDataStb", oDATA_STB, 0);
    chk("rstErrT", oERR_TIMING, 0);
    chk("rstErrB", oERR_BUSY, 0);
  endtask

  function automatic int expDur(input logic [7:0] d, input logic rs);
    if (rs) return BUSY;
    if (d == 0) return 0;
    if (d == 1 || d[7:1] == 7'd1) return CLR;
    return BUSY;
  endfunction

  initial begin
    int n, e1;
    tbl = '{
      '{8'h38,0,7'h00,1,0,1,0}, '{8'h0C,0,7'h00,1,0,1,1},
      '{8'h01,0,7'h00,1,0,1,1}, '{8'h06,0,7'h00,1,0,1,1},
      '{8'h80,0,7'h00,1,0,1,1}, '{8'h57,1,7'h01,0,1,1,1},
      '{8'h65,1,7'h02,0,1,1,1}, '{8'hC0,0,7'h40,1,0,1,1},
      '{8'h45,1,7'h41,0,1,1,1}, '{8'hA7,0,7'h27,1,0,1,1},
      '{8'h41,1,7'h40,0,1,1,1}, '{8'h04,0,7'h40,1,0,1,1},
      '{8'h42,1,7'h27,0,1,1,1}, '{8'h00,0,7'h27,0,0,1,1},
      '{8'h14,0,7'h40,1,0,1,1}, '{8'h10,0,7'h27,1,0,1,1},
      '{8'h18,0,7'h27,1,0,1,1}, '{8'h80,0,7'h00,1,0,1,1},
      '{8'h10,0,7'h67,1,0,1,1}, '{8'h14,0,7'h00,1,0,1,1},
      '{8'h08,0,7'h00,1,0,1,0}, '{8'h30,0,7'h00,1,0,0,0},
      '{8'h40,0,7'h00,1,0,0,0}, '{8'h3C,0,7'h00,1,0,1,0},
      '{8'h0F,0,7'h00,1,0,1,1}, '{8'h86,0,7'h06,1,0,1,1},
      '{8'h02,0,7'h00,1,0,1,1}, '{8'h06,0,7'h00,1,0,1,1}
    };

    modelReset();
    #1 iRST_N = 1'b0;
    #2 chkResetOuts();
    repeat (3) tick();
    iRST_N = 1'b1;
    tick();
    checkBuf();

    // init, line change, wrap and decrement vectors
    for (int i = 0; i < 28; i++) begin
      pulse(tbl[i].d, tbl[i].rs, 1'b0, 18);
      chk($sformatf("v%0d ac", i), oAC, tbl[i].ac);
      chk($sformatf("v%0d cs", i), oCMD_STB, tbl[i].cs);
      chk($sformatf("v%0d ds", i), oDATA_STB, tbl[i].ds);
      chk($sformatf("v%0d fok", i), oFUNC_OK, tbl[i].fok);
      chk($sformatf("v%0d don", i), oDISP_ON, tbl[i].don);
      n = 0;
      while (oBUSY === 1'b1 && n < 1000) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d busyLen", i), n, expDur(tbl[i].d, tbl[i].rs));
    end
    chk("errFlagsInit", {oERR_TIMING, oERR_BUSY}, 0);
    checkBuf();
    iRD_ADDR = 5'd0;  tick(); chk("entry0", oRD_CHAR, 8'h57);
    iRD_ADDR = 5'd1;  tick(); chk("entry1", oRD_CHAR, 8'h65);
    iRD_ADDR = 5'd16; tick(); chk("entry16", oRD_CHAR, 8'h42);

    // busy violation and strobe width
    pulse(8'h85, 1'b0, 1'b0, 8);
    tick();
    chk("cmdStbWidth", oCMD_STB, 0);
    waitIdle();
    pulse(8'h31, 1'b1, 1'b0, 8);
    e1 = cyc;
    tick();
    chk("dataStbWidth", oDATA_STB, 0);
    pulse(8'h32, 1'b1, 1'b0, 8);
    chk("busyViol", oERR_BUSY, 1);
    chk("busyViolAc", oAC, 7'h06);
    waitIdle();
    chk("busyEndCycle", cyc - e1, BUSY);
    iRD_ADDR = 5'd5; tick(); chk("entry5", oRD_CHAR, 8'h31);

    // short EN pulses, and the acceptance boundary
    pulse(8'h55, 1'b1, 1'b0, 3);
    chk("shortBusy", oBUSY, 0);
    chk("shortAc", oAC, 7'h06);
    chk("shortErr", oERR_TIMING, 1);
    pulse(8'h56, 1'b1, 1'b0, EMIN - 1);
    pulse(8'h57, 1'b1, 1'b0, EMIN);
    chk("minPulseAc", oAC, 7'h07);
    waitIdle();
    pulse(8'h58, 1'b1, 1'b1, 12);
    chk("readIgnored", oAC, 7'h07);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      pulse(8'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), $urandom_range(2, 12));
      repeat ($urandom_range(0, 70)) tick();
    end
    waitIdle();
    checkBuf();

    // reset in the middle of a clear
    pulse(8'h80, 1'b0, 1'b0, 8);
    waitIdle();
    pulse(8'h06, 1'b0, 1'b0, 8);
    waitIdle();
    for (int i = 0; i < 6; i++) begin
      pulse(8'(8'h61 + i), 1'b1, 1'b0, 8);
      waitIdle();
    end
    pulse(8'h01, 1'b0, 1'b0, 8);
    iRD_ADDR = 5'd3; tick();
    chk("rdMidClearOld", oRD_CHAR, 8'h64);
    iRD_ADDR = 5'd0; tick();
    chk("rdMidClearNew", oRD_CHAR, 8'h20);
    tick();
    iRST_N = 1'b0;
    #1 chkResetOuts();
    modelReset();
    tick();
    chkResetOuts();
    iRST_N = 1'b1;
    iRD_ADDR = 5'd0;
    tick();
    chk("rdAfterReset", oRD_CHAR, 8'h20);
    checkBuf();
    pulse(8'h7A, 1'b1, 1'b0, 8);
    chk("incAfterReset", oAC, 7'h01);
    waitIdle();
    iRD_ADDR = 5'd0; tick(); chk("writeAfterReset", oRD_CHAR, 8'h7A);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErr);
    $finish;
  end

endmodule
